// File: rtl/ad_pulse_gen_pkg.sv
// Shared types and helpers for the AD pulse generator: FSM state encoding,
// AD sample width constants and the saturating threshold function.
package ad_pulse_pkg;

  localparam int AD_W = 8;
  localparam logic [AD_W-1:0] AD_MAX = 8'd255;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_QUAL = 2'd1,
    HIGH      = 2'd2,
    FALL_QUAL = 2'd3
  } pulse_state_t;

  // Worked on AD_W+1 bits: a carry clamps to AD_MAX and a borrow clamps to 0.
  function automatic logic [AD_W-1:0] sat_thresh(input logic [AD_W-1:0] level,
                                                 input logic [AD_W-1:0] hyst,
                                                 input logic            up);
    logic [AD_W:0] s;
    logic [AD_W-1:0] r;
    if (up) begin
      s = {1'b0, level} + {1'b0, hyst};
      r = s[AD_W] ? AD_MAX : s[AD_W-1:0];
    end else begin
      s = {1'b0, level} - {1'b0, hyst};
      r = s[AD_W] ? '0 : s[AD_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ad_pulse_gen_period_cnt.sv
// Period counter: measures ad_clk cycles between accepted rising edges and
// flags loss of signal when no edge arrives within TIMEOUT cycles.
module pulse_period_cnt #(
  parameter int                  PERIOD_W = 24,
  parameter logic [PERIOD_W-1:0] TIMEOUT  = 24'd5_000_000
) (
  input  logic                ad_clk,
  input  logic                rst,
  input  logic                rise_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                no_signal
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_M1 = PERIOD_W'(TIMEOUT - 1);

  logic [PERIOD_W-1:0] per_cnt;
  logic                armed;

  // period_valid is a single-cycle strobe with no back-pressure: period is
  // stable from that cycle until the next strobe and must be taken when seen.
  always_ff @(posedge ad_clk) begin
    if (rst) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise_strobe) begin
        if (armed) begin
          period       <= per_cnt;
          period_valid <= 1'b1;
          no_signal    <= 1'b0;
        end
        per_cnt <= PERIOD_W'(1);
        armed   <= 1'b1;
      end else if (per_cnt == TIMEOUT_M1) begin
        // Counter reaches TIMEOUT on this edge: declare loss of signal.
        per_cnt   <= TIMEOUT;
        no_signal <= 1'b1;
        armed     <= 1'b0;
      end else if (per_cnt != TIMEOUT) begin
        per_cnt <= per_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad_pulse_gen.sv
// Hysteresis comparator with minimum-dwell qualification turning the AD sample
// stream into a clean square wave, plus period / loss-of-signal measurement.
module ad_pulse_gen
  import ad_pulse_pkg::*;
#(
  parameter logic [AD_W-1:0]     HYST      = 8'd10,
  parameter int                  MIN_DWELL = 4,
  parameter int                  PERIOD_W  = 24,
  parameter logic [PERIOD_W-1:0] TIMEOUT   = 24'd5_000_000
) (
  input  logic                ad_clk,
  input  logic                rst,
  input  logic [AD_W-1:0]     ad_data,
  input  logic [AD_W-1:0]     trig_level,
  output logic                ad_pulse,
  output logic                rise_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                no_signal,
  output pulse_state_t        dbg_state
);

  localparam logic [3:0] MIN_D = 4'(MIN_DWELL);

  pulse_state_t    state;
  logic [3:0]      dwell;
  logic [3:0]      dwell_inc;
  logic [AD_W-1:0] hi;
  logic [AD_W-1:0] lo;
  logic            rise_q;
  logic            fall_q;
  logic            rise_now;

  assign hi        = sat_thresh(trig_level, HYST, 1'b1);
  assign lo        = sat_thresh(trig_level, HYST, 1'b0);
  assign rise_q    = (ad_data >= hi);
  assign fall_q    = (ad_data <= lo);
  assign dwell_inc = dwell + 4'd1;

  // True on the cycle whose clock edge moves the FSM into HIGH.
  assign rise_now = rise_q &&
                    (((state == LOW) && (MIN_D == 4'd1)) ||
                     ((state == RISE_QUAL) && (dwell_inc == MIN_D)));

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      state       <= LOW;
      dwell       <= '0;
      ad_pulse    <= 1'b0;
      rise_strobe <= 1'b0;
    end else begin
      rise_strobe <= rise_now;
      case (state)
        LOW: begin
          if (rise_q) begin
            if (MIN_D == 4'd1) begin
              state    <= HIGH;
              ad_pulse <= 1'b1;
            end else begin
              state <= RISE_QUAL;
              dwell <= 4'd1;
            end
          end
        end
        RISE_QUAL: begin
          if (!rise_q) begin
            state <= LOW;
            dwell <= '0;
          end else if (dwell_inc == MIN_D) begin
            state    <= HIGH;
            dwell    <= '0;
            ad_pulse <= 1'b1;
          end else begin
            dwell <= dwell_inc;
          end
        end
        HIGH: begin
          if (fall_q) begin
            if (MIN_D == 4'd1) begin
              state    <= LOW;
              ad_pulse <= 1'b0;
            end else begin
              state <= FALL_QUAL;
              dwell <= 4'd1;
            end
          end
        end
        FALL_QUAL: begin
          if (!fall_q) begin
            state <= HIGH;
            dwell <= '0;
          end else if (dwell_inc == MIN_D) begin
            state    <= LOW;
            dwell    <= '0;
            ad_pulse <= 1'b0;
          end else begin
            dwell <= dwell_inc;
          end
        end
        default: begin
          state <= LOW;
          dwell <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  pulse_period_cnt #(
    .PERIOD_W (PERIOD_W),
    .TIMEOUT  (TIMEOUT)
  ) u_period_cnt (
    .ad_clk       (ad_clk),
    .rst          (rst),
    .rise_strobe  (rise_now),
    .period       (period),
    .period_valid (period_valid),
    .no_signal    (no_signal)
  );

endmodule

// File: tb/tb_ad_pulse_gen.sv
// Randomized scoreboard bench for ad_pulse_gen: a sample-window reference model
// pushes per-cycle expectations and period values; a monitor pops and compares.
module tb_ad_pulse_gen;
  import ad_pulse_pkg::*;

  localparam logic [7:0]  HYST      = 8'd10;
  localparam int          MIN_DWELL = 4;
  localparam int          PERIOD_W  = 24;
  localparam int          TIMEOUT   = 1000;

  // clock / reset
  logic                ad_clk;
  logic                rst;
  logic [7:0]          ad_data;
  logic [7:0]          trig_level;
  logic                ad_pulse;
  logic                rise_strobe;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                no_signal;
  pulse_state_t        dbg_state;

  initial begin
    ad_clk = 1'b0;
    forever #5 ad_clk = ~ad_clk;
  end

  ad_pulse_gen #(
    .HYST      (HYST),
    .MIN_DWELL (MIN_DWELL),
    .PERIOD_W  (PERIOD_W),
    .TIMEOUT   (PERIOD_W'(TIMEOUT))
  ) dut (
    .ad_clk       (ad_clk),
    .rst          (rst),
    .ad_data      (ad_data),
    .trig_level   (trig_level),
    .ad_pulse     (ad_pulse),
    .rise_strobe  (rise_strobe),
    .period       (period),
    .period_valid (period_valid),
    .no_signal    (no_signal),
    .dbg_state    (dbg_state)
  );

  // scoreboard: {state[1:0], ad_pulse, rise_strobe, period_valid, no_signal}
  logic [5:0]          exp_q[$];
  logic [PERIOD_W-1:0] per_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model: behaviour from the last MIN_DWELL samples and edge timestamps
  logic m_lvl;
  int   m_rrun, m_frun;
  logic m_armed, m_nosig;
  int   m_cyc = 0;
  int   m_tlast = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] d, input logic [7:0] tl, input logic r);
    int hi, lo;
    logic strobe, pv;
    logic [1:0] st;
    strobe = 1'b0;
    pv     = 1'b0;
    if (r) begin
      m_lvl   = 1'b0;
      m_rrun  = 0;
      m_frun  = 0;
      m_armed = 1'b0;
      m_nosig = 1'b0;
      m_tlast = m_cyc + 1;
    end else begin
      hi = (int'(tl) + int'(HYST) > 255) ? 255 : int'(tl) + int'(HYST);
      lo = (int'(tl) < int'(HYST)) ? 0 : int'(tl) - int'(HYST);
      m_rrun = (int'(d) >= hi) ? m_rrun + 1 : 0;
      m_frun = (int'(d) <= lo) ? m_frun + 1 : 0;
      if (!m_lvl && m_rrun >= MIN_DWELL) begin
        m_lvl  = 1'b1;
        strobe = 1'b1;
      end else if (m_lvl && m_frun >= MIN_DWELL) begin
        m_lvl = 1'b0;
      end
      if (strobe) begin
        if (m_armed) begin
          pv = 1'b1;
          per_q.push_back(PERIOD_W'(m_cyc - m_tlast));
          m_nosig = 1'b0;
        end
        m_armed = 1'b1;
        m_tlast = m_cyc;
      end else if (m_cyc - m_tlast == TIMEOUT - 1) begin
        m_nosig = 1'b1;
        m_armed = 1'b0;
      end
    end
    if (!m_lvl) st = (m_rrun > 0) ? RISE_QUAL : LOW;
    else        st = (m_frun > 0) ? FALL_QUAL : HIGH;
    exp_q.push_back({st, m_lvl, strobe, pv, m_nosig});
    m_cyc++;
  endtask

  // driver
  task automatic drive(input logic [7:0] d, input logic [7:0] tl, input logic r);
    @(negedge ad_clk);
    ad_data    = d;
    trig_level = tl;
    rst        = r;
    model_step(d, tl, r);
  endtask

  task automatic hold(input int n, input logic [7:0] d, input logic [7:0] tl);
    for (int i = 0; i < n; i++) drive(d, tl, 1'b0);
  endtask

  // monitor
  logic [5:0] mon_e;
  always @(posedge ad_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state",        32'(dbg_state),    32'(mon_e[5:4]));
      chk("ad_pulse",     32'(ad_pulse),     32'(mon_e[3]));
      chk("rise_strobe",  32'(rise_strobe),  32'(mon_e[2]));
      chk("period_valid", 32'(period_valid), 32'(mon_e[1]));
      chk("no_signal",    32'(no_signal),    32'(mon_e[0]));
      if (mon_e[1] && per_q.size() > 0) chk("period", 32'(period), 32'(per_q.pop_front()));
    end
  end

  // stimulus
  initial begin
    int rtl;
    rst        = 1'b1;
    ad_data    = 8'd0;
    trig_level = 8'd128;

    for (int i = 0; i < 3; i++) drive(8'd50, 8'd128, 1'b1);

    // clean square wave, 40/40 at trig 128
    for (int p = 0; p < 5; p++) begin
      hold(40, 8'd200, 8'd128);
      hold(40, 8'd50, 8'd128);
    end

    // glitch rejection
    hold(10, 8'd50, 8'd128);
    hold(3, 8'd200, 8'd128);
    hold(10, 8'd50, 8'd128);

    // hysteresis chatter inside the band
    for (int i = 0; i < 100; i++) begin
      drive(8'd130, 8'd128, 1'b0);
      drive(8'd126, 8'd128, 1'b0);
    end

    // saturated thresholds at both ends
    hold(10, 8'd254, 8'd250);
    hold(6, 8'd255, 8'd250);
    hold(10, 8'd1, 8'd5);
    hold(6, 8'd0, 8'd5);

    // timeout: one rise, silence, then re-arm and measure
    hold(6, 8'd200, 8'd128);
    hold(1100, 8'd50, 8'd128);
    for (int p = 0; p < 3; p++) begin
      hold(30, 8'd200, 8'd128);
      hold(30, 8'd50, 8'd128);
    end

    // reset mid-count and mid RISE_QUAL
    hold(2, 8'd200, 8'd128);
    drive(8'd200, 8'd128, 1'b1);
    hold(5, 8'd200, 8'd128);
    hold(20, 8'd50, 8'd128);
    hold(20, 8'd200, 8'd128);
    hold(20, 8'd50, 8'd128);
    hold(20, 8'd200, 8'd128);

    // randomized segments around a wandering trigger level
    rtl = 128;
    for (int s = 0; s < 300; s++) begin
      int len, v;
      logic up;
      if ($urandom_range(0, 3) == 0) rtl = int'($urandom_range(0, 255));
      up  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        if (up) v = rtl + int'($urandom_range(0, 40));
        else    v = rtl - int'($urandom_range(0, 40));
        if (v > 255) v = 255;
        if (v < 0)   v = 0;
        drive(8'(v), 8'(rtl), ($urandom_range(0, 399) == 0));
      end
    end

    hold(4, 8'd50, 8'd128);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge ad_clk);
    #2;
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
    chk("drain_per_q", 32'(per_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
